// File: rtl/sierpinski_seq_ctrl.sv
// Command sequencer for the 8-bit Sierpinski/LFSR datapath: seed load, bounded and free runs, row framing.
// Optional period measurement is compiled in with `define PERIOD_DETECT_EN.
module sierpinski_seq_ctrl #(
  parameter int          ROW_LEN  = 16,
  parameter int          CNT_W    = 16,
  parameter logic [7:0]  ZERO_SUB = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic             halt,
  output logic             lfsr_load,
  output logic [7:0]       lfsr_seed,
  output logic             lfsr_step,
  input  logic [7:0]       lfsr_state,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             row_strobe,
  output logic [CNT_W-1:0] step_count,
  output logic             period_valid,
  output logic [CNT_W-1:0] period
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FREE} state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_FREE = 2'd2;
  localparam logic [7:0] COL_LAST = 8'(ROW_LEN - 1);

  state_t           state_q, state_d;
  logic [7:0]       seed_q, seed_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [7:0]       col_q, col_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             row_strobe_q, row_strobe_d;
  logic             stepping;

  assign stepping = (state_q == RUN) || (state_q == FREE);

`ifdef PERIOD_DETECT_EN
  logic             step_d1_q, step_d1_d;
  logic             period_valid_q, period_valid_d;
  logic [CNT_W-1:0] period_q, period_d;
`endif

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    remaining_d  = remaining_q;
    col_d        = col_q;
    step_count_d = step_count_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    row_strobe_d = 1'b0;

    if (stepping) begin
      step_count_d = step_count_q + 1'b1;
      if (col_q == COL_LAST) begin
        col_d        = 8'd0;
        row_strobe_d = 1'b1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              seed_d  = (cmd_data == 8'd0) ? ZERO_SUB : cmd_data;
              state_d = LOAD;
            end
            OP_RUN: begin
              if (cmd_data == 8'd0) begin
                done_d = 1'b1;
              end else begin
                remaining_d = cmd_data;
                state_d     = RUN;
              end
            end
            OP_FREE: state_d = FREE;
            default: ;
          endcase
        end
      end
      LOAD: begin
        step_count_d = '0;
        col_d        = 8'd0;
        state_d      = IDLE;
      end
      RUN: begin
        remaining_d = remaining_q - 8'd1;
        // A halt landing on the final step still counts as a normal completion.
        if (remaining_q == 8'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (halt) begin
          state_d     = IDLE;
          remaining_d = 8'd0;
          done_d      = 1'b1;
          aborted_d   = 1'b1;
        end
      end
      FREE: begin
        if (halt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PERIOD_DETECT_EN
  // lfsr_state reflects a step one cycle later, so the compare uses the delayed step flag.
  always_comb begin
    step_d1_d      = stepping;
    period_valid_d = period_valid_q;
    period_d       = period_q;
    if (state_q == LOAD) begin
      period_valid_d = 1'b0;
      period_d       = '0;
    end else if (step_d1_q && !period_valid_q && (lfsr_state == seed_q) &&
                 (step_count_q != '0)) begin
      period_valid_d = 1'b1;
      period_d       = step_count_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      seed_q       <= ZERO_SUB;
      remaining_q  <= 8'd0;
      col_q        <= 8'd0;
      step_count_q <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      row_strobe_q <= 1'b0;
`ifdef PERIOD_DETECT_EN
      step_d1_q      <= 1'b0;
      period_valid_q <= 1'b0;
      period_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      remaining_q  <= remaining_d;
      col_q        <= col_d;
      step_count_q <= step_count_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      row_strobe_q <= row_strobe_d;
`ifdef PERIOD_DETECT_EN
      step_d1_q      <= step_d1_d;
      period_valid_q <= period_valid_d;
      period_q       <= period_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign lfsr_load  = (state_q == LOAD);
  assign lfsr_step  = stepping;
  assign busy       = (state_q != IDLE);
  assign lfsr_seed  = seed_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign row_strobe = row_strobe_q;
  assign step_count = step_count_q;

`ifdef PERIOD_DETECT_EN
  assign period_valid = period_valid_q;
  assign period       = period_q;
`else
  logic unused_lfsr_state;
  assign unused_lfsr_state = ^lfsr_state;
  assign period_valid      = 1'b0;
  assign period            = '0;
`endif

endmodule

// File: tb/tb_sierpinski_seq_ctrl.sv
// Scoreboard bench for sierpinski_seq_ctrl with a behavioural Fibonacci LFSR datapath (x^8+x^6+x^5+x^4+1).
module tb_sierpinski_seq_ctrl;
  localparam int ROW_LEN = 16;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, halt;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data, lfsr_seed, lfsr_state;
  logic        lfsr_load, lfsr_step, busy, done, aborted, row_strobe, period_valid;
  logic [15:0] step_count, period;

  always #5 clk = ~clk;

  sierpinski_seq_ctrl #(.ROW_LEN(ROW_LEN), .CNT_W(16), .ZERO_SUB(8'h01)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .halt(halt), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .lfsr_step(lfsr_step), .lfsr_state(lfsr_state), .busy(busy), .done(done),
    .aborted(aborted), .row_strobe(row_strobe), .step_count(step_count),
    .period_valid(period_valid), .period(period)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always @(posedge clk) begin
    if (rst)            lfsr_state <= 8'h00;
    else if (lfsr_load) lfsr_state <= lfsr_seed;
    else if (lfsr_step) lfsr_state <= lfsr_next(lfsr_state);
  end

  typedef struct { logic ab; logic [15:0] cnt; } done_exp_t;
  logic [7:0]  load_q[$];
  done_exp_t   done_q[$];
  logic [15:0] row_q[$];

  int          tests = 0, fails = 0;
  int          step_seen = 0;
  logic [15:0] m_steps = 16'd0;
  int          m_col = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_steps(input int k);
    for (int i = 0; i < k; i++) begin
      m_steps++;
      m_col++;
      if (m_col == ROW_LEN) begin
        m_col = 0;
        row_q.push_back(m_steps);
      end
    end
  endfunction

  // Monitor: every DUT event must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (lfsr_step) step_seen++;
      if (lfsr_load) begin
        if (load_q.size() == 0) check("unexpected_load", 1, 0);
        else check("load_seed", lfsr_seed, load_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          done_exp_t e;
          e = done_q.pop_front();
          check("done_aborted", aborted, e.ab);
          check("done_step_count", step_count, e.cnt);
        end
      end
      if (row_strobe) begin
        if (row_q.size() == 0) check("unexpected_row_strobe", 1, 0);
        else check("row_strobe_step", step_count, row_q.pop_front());
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    bit ok = 0;
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [7:0] seed);
    logic [7:0] exp_seed;
    exp_seed = (seed == 8'h00) ? 8'h01 : seed;
    load_q.push_back(exp_seed);
    issue(2'd0, seed);
    check("load_ready_low", cmd_ready, 0);
    m_steps = 16'd0; m_col = 0;
    @(posedge clk); #1;
    check("load_step_count_clear", step_count, 0);
    check("load_seed_held", lfsr_seed, exp_seed);
  endtask

  task automatic do_run(input int n, input int h);
    int k, s0;
    done_exp_t e;
    k = (h == 0 || h > n) ? n : h;
    model_steps(k);
    e.ab = (h != 0 && h < n); e.cnt = m_steps;
    done_q.push_back(e);
    s0 = step_seen;
    issue(2'd1, 8'(n));
    if (n > 0) begin
      check("run_busy", {cmd_ready, busy}, 2'b01);
      if (h != 0 && h <= n) begin
        repeat (h - 1) begin @(posedge clk); #1; end
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
      end else begin
        repeat (n) begin @(posedge clk); #1; end
      end
    end
    @(posedge clk); #1;
    check("run_step_cycles", step_seen - s0, k);
  endtask

  task automatic do_free(input int k);
    int s0;
    model_steps(k);
    s0 = step_seen;
    issue(2'd2, 8'($urandom));
    repeat (k - 1) begin @(posedge clk); #1; end
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    check("free_step_count", step_count, m_steps);
    check("free_idle", busy, 0);
    @(posedge clk); #1;
    check("free_step_cycles", step_seen - s0, k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_period, s0;
    logic [7:0] s;
    done_exp_t e;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd3; cmd_data = 8'h00; halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_seed", lfsr_seed, 8'h01);
    check("reset_strobes", {lfsr_load, lfsr_step, busy, done, aborted, row_strobe}, 6'b0);
    check("reset_step_count", step_count, 0);
    check("reset_period", {period_valid, period}, 17'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_load(8'h5A);
    do_load(8'h00);
    do_run(40, 0);
    check("run40_step_count", step_count, 40);
    do_run(0, 0);
    do_run(10, 4);
    do_run(10, 10);

    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0: do_load(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        1: begin
          int n, h;
          n = $urandom_range(0, 40);
          h = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
          do_run(n, h);
        end
        2: do_free($urandom_range(1, 40));
        default: begin
          issue(2'd3, 8'($urandom));
          halt = 1'b1;
          @(posedge clk); #1;
          halt = 1'b0;
          check("nop_idle", busy, 0);
        end
      endcase
    end

    // Reset in the middle of a run: no done pulse, counters back to zero.
    do_load(8'h33);
    issue(2'd1, 8'd50);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_steps = 16'd0; m_col = 0;
    check("midrun_reset_idle", {busy, done, lfsr_step}, 3'b0);
    check("midrun_reset_count", step_count, 0);
    check("midrun_reset_seed", lfsr_seed, 8'h01);
    @(posedge clk); #1;

    // Free run 300 steps from seed 01, with a command held across the halt.
    s = 8'h01; exp_period = 0;
    do begin s = lfsr_next(s); exp_period++; end while (s != 8'h01 && exp_period < 1000);
    do_load(8'h01);
    model_steps(300);
    s0 = step_seen;
    issue(2'd2, 8'h00);
    repeat (299) begin @(posedge clk); #1; end
    model_steps(5);
    e.ab = 1'b0; e.cnt = m_steps;
    done_q.push_back(e);
    halt = 1'b1; cmd_op = 2'd1; cmd_data = 8'd5; cmd_valid = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    check("free300_step_count", step_count, 300);
    check("held_cmd_ready_first_idle", cmd_ready, 1);
    check("free300_step_cycles", step_seen - s0, 300);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("held_cmd_accepted", busy, 1);
    repeat (5) begin @(posedge clk); #1; end
    @(posedge clk); #1;
`ifdef PERIOD_DETECT_EN
    check("period_valid_set", period_valid, 1);
    check("period_value", period, exp_period);
`else
    check("period_disabled", {period_valid, period}, 17'h0);
`endif
    do_load(8'h5A);
    check("period_cleared_by_load", period_valid, 0);

    repeat (4) begin @(posedge clk); #1; end
    check("queues_drained", load_q.size() + done_q.size() + row_q.size(), 0);
    check("final_step_count", step_count, m_steps);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
